// File: rtl/paddle_position_tracker.sv
// -----------------------------------------------------------------------------
// paddle_position_tracker
//
// Purpose:
//   Position register for one player's paddle. A button press produces an
//   immediate step, then after a hold delay the paddle auto-repeats at a fixed
//   period. Motion saturates at POS_MIN and at the width-dependent upper limit
//   (POS_MAX - paddlewidth). Limit flags are registered together with the
//   position so that they always describe the value currently on pos.
//
// Optional feature (compile-time macro PADDLE_ACCEL_EN):
//   When defined, the repeat steps are counted and, once ACCEL_AFTER repeat
//   steps have occurred in the current hold, the step size doubles until the
//   button is released. When undefined, the step size is always STEP.
//
// Ports:
//   clk          in   1      system clock, all state on rising edge
//   reset_n      in   1      asynchronous active-low reset
//   btn_dec      in   1      debounced level: move toward POS_MIN
//   btn_inc      in   1      debounced level: move toward upper limit
//   recenter     in   1      synchronous load of POS_INIT, forces IDLE
//   paddlewidth  in   6      paddle length in pixels
//   pos          out  POS_W  current paddle position
//   at_min       out  1      registered: pos == POS_MIN
//   at_max       out  1      registered: pos == upper limit
//   moving       out  1      registered: hold or auto-repeat in progress
// -----------------------------------------------------------------------------
module paddle_position_tracker #(
    parameter int POS_W         = 9,
    parameter int POS_MIN       = 10,
    parameter int POS_MAX       = 470,
    parameter int POS_INIT      = 220,
    parameter int STEP          = 1,
    parameter int REPEAT_DELAY  = 4,
    parameter int REPEAT_PERIOD = 2,
    parameter int ACCEL_AFTER   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn_dec,
    input  logic             btn_inc,
    input  logic             recenter,
    input  logic [5:0]       paddlewidth,
    output logic [POS_W-1:0] pos,
    output logic             at_min,
    output logic             at_max,
    output logic             moving
);

    // One extra bit of headroom so that pos+step and limit math never wrap.
    localparam int W1      = POS_W + 1;
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [W1-1:0]    MIN_W1  = W1'(POS_MIN);
    localparam logic [W1-1:0]    MAX_W1  = W1'(POS_MAX);
    localparam logic [W1-1:0]    INIT_W1 = W1'(POS_INIT);
    localparam logic [CNT_W-1:0] DLY_END = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_END = CNT_W'(REPEAT_PERIOD - 1);

    // Reset flag values are constants; the upper limit depends on a live
    // input, so only the fixed playfield bounds are used here.
    localparam logic RST_AT_MIN = (POS_INIT <= POS_MIN);
    localparam logic RST_AT_MAX = (POS_INIT >= POS_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_dir;
    logic [CNT_W-1:0]  r_cnt;
    logic [POS_W-1:0]  r_pos;
    logic              r_at_min;
    logic              r_at_max;
    logic              r_moving;

    logic [W1-1:0]     w_hi;
    logic [W1-1:0]     w_hi_raw;
    logic [W1-1:0]     w_pos_ext;
    logic [W1-1:0]     w_step_size;
    logic [W1-1:0]     w_step_pos;
    logic [W1-1:0]     w_init_clamped;
    logic [W1-1:0]     w_pos_next;
    logic              w_one;
    logic              w_dir;
    logic              w_keep;
    logic              w_step;
    logic              w_rpt_step;

`ifdef PADDLE_ACCEL_EN
    localparam int ACC_W = (ACCEL_AFTER > 0) ? $clog2(ACCEL_AFTER + 1) : 1;
    logic [ACC_W-1:0] r_rpt_cnt;

    // Counts repeat steps within the current hold; saturates once the
    // acceleration threshold is reached and clears whenever the FSM is idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rpt_cnt <= '0;
        end else if (recenter || !w_keep || (r_state == ST_IDLE)) begin
            r_rpt_cnt <= '0;
        end else if (w_rpt_step && (r_rpt_cnt < ACC_W'(ACCEL_AFTER))) begin
            r_rpt_cnt <= r_rpt_cnt + ACC_W'(1);
        end
    end

    assign w_step_size = (r_rpt_cnt >= ACC_W'(ACCEL_AFTER)) ? W1'(2 * STEP) : W1'(STEP);
`else
    logic w_unused_accel;
    assign w_unused_accel = (ACCEL_AFTER != 0);
    assign w_step_size    = W1'(STEP);
`endif

    always_comb begin
        w_hi_raw       = '0;
        w_hi           = MIN_W1;
        w_pos_ext      = {1'b0, r_pos};
        w_step_pos     = w_pos_ext;
        w_init_clamped = INIT_W1;
        w_pos_next     = w_pos_ext;

        // Upper limit; a paddle wider than the playfield pins it to POS_MIN.
        if (W1'(paddlewidth) <= MAX_W1) begin
            w_hi_raw = MAX_W1 - W1'(paddlewidth);
            if (w_hi_raw >= MIN_W1) begin
                w_hi = w_hi_raw;
            end
        end

        w_one  = btn_dec ^ btn_inc;
        w_dir  = btn_inc;
        // Outside IDLE, a direction change counts as a release.
        w_keep = w_one && ((r_state == ST_IDLE) || (w_dir == r_dir));

        w_rpt_step = w_keep && (((r_state == ST_HOLD) && (r_cnt == DLY_END)) ||
                                ((r_state == ST_RPT)  && (r_cnt == PER_END)));
        w_step     = w_rpt_step || (w_keep && (r_state == ST_IDLE));

        // Saturating step
        if (w_dir) begin
            if (w_pos_ext + w_step_size > w_hi) begin
                w_step_pos = w_hi;
            end else begin
                w_step_pos = w_pos_ext + w_step_size;
            end
        end else begin
            if (w_pos_ext < MIN_W1 + w_step_size) begin
                w_step_pos = MIN_W1;
            end else begin
                w_step_pos = w_pos_ext - w_step_size;
            end
        end

        if (INIT_W1 < MIN_W1) begin
            w_init_clamped = MIN_W1;
        end else if (INIT_W1 > w_hi) begin
            w_init_clamped = w_hi;
        end

        // Priority: recenter, then range repair, then motion.
        if (recenter) begin
            w_pos_next = w_init_clamped;
        end else if (w_pos_ext > w_hi) begin
            w_pos_next = w_hi;
        end else if (w_pos_ext < MIN_W1) begin
            w_pos_next = MIN_W1;
        end else if (w_step) begin
            w_pos_next = w_step_pos;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_dir    <= 1'b0;
            r_cnt    <= '0;
            r_pos    <= POS_W'(POS_INIT);
            r_at_min <= RST_AT_MIN;
            r_at_max <= RST_AT_MAX;
            r_moving <= 1'b0;
        end else begin
            r_pos    <= w_pos_next[POS_W-1:0];
            r_at_min <= (w_pos_next == MIN_W1);
            r_at_max <= (w_pos_next == w_hi);

            if (recenter) begin
                r_state  <= ST_IDLE;
                r_cnt    <= '0;
                r_moving <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_one) begin
                            r_state  <= ST_HOLD;
                            r_dir    <= w_dir;
                            r_cnt    <= '0;
                            r_moving <= 1'b1;
                        end else begin
                            r_moving <= 1'b0;
                        end
                    end
                    ST_HOLD: begin
                        if (!w_keep) begin
                            r_state  <= ST_IDLE;
                            r_cnt    <= '0;
                            r_moving <= 1'b0;
                        end else if (r_cnt == DLY_END) begin
                            r_state  <= ST_RPT;
                            r_cnt    <= '0;
                            r_moving <= 1'b1;
                        end else begin
                            r_cnt    <= r_cnt + CNT_W'(1);
                            r_moving <= 1'b1;
                        end
                    end
                    ST_RPT: begin
                        if (!w_keep) begin
                            r_state  <= ST_IDLE;
                            r_cnt    <= '0;
                            r_moving <= 1'b0;
                        end else if (r_cnt == PER_END) begin
                            r_cnt    <= '0;
                            r_moving <= 1'b1;
                        end else begin
                            r_cnt    <= r_cnt + CNT_W'(1);
                            r_moving <= 1'b1;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_cnt    <= '0;
                        r_moving <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pos    = r_pos;
    assign at_min = r_at_min;
    assign at_max = r_at_max;
    assign moving = r_moving;

endmodule

// File: tb/tb_paddle_position_tracker.sv
module tb_paddle_position_tracker;

    localparam int POS_W   = 9;
    localparam int P_MIN   = 10;
    localparam int P_MAX   = 470;
    localparam int P_INIT  = 220;
    localparam int P_STEP  = 1;
    localparam int R_DLY   = 4;
    localparam int R_PER   = 2;
    localparam int A_AFTER = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             btn_dec;
    logic             btn_inc;
    logic             recenter;
    logic [5:0]       paddlewidth;
    logic [POS_W-1:0] pos;
    logic             at_min;
    logic             at_max;
    logic             moving;

    int total = 0;
    int bad   = 0;

    // Reference model: press age since the hold began.
    int m_pos;
    bit m_hold;
    bit m_dir;
    int m_age;
    int m_hi;

    paddle_position_tracker #(
        .POS_W(POS_W), .POS_MIN(P_MIN), .POS_MAX(P_MAX), .POS_INIT(P_INIT),
        .STEP(P_STEP), .REPEAT_DELAY(R_DLY), .REPEAT_PERIOD(R_PER), .ACCEL_AFTER(A_AFTER)
    ) dut (
        .clk(clk), .reset_n(reset_n), .btn_dec(btn_dec), .btn_inc(btn_inc),
        .recenter(recenter), .paddlewidth(paddlewidth), .pos(pos),
        .at_min(at_min), .at_max(at_max), .moving(moving)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int upper_limit(input int pw);
        int h;
        h = P_MAX - pw;
        if (h < P_MIN) h = P_MIN;
        return h;
    endfunction

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_edge();
        bit one;
        bit step;
        int size;
        int idx;
        int init_c;
        m_hi = upper_limit(int'(paddlewidth));
        one  = btn_dec ^ btn_inc;
        step = 0;
        size = P_STEP;
        if (recenter) begin
            m_hold = 0;
        end else if (!one || (m_hold && (btn_inc != m_dir))) begin
            m_hold = 0;
        end else if (!m_hold) begin
            m_hold = 1;
            m_dir  = btn_inc;
            m_age  = 0;
            step   = 1;
        end else begin
            m_age++;
            if (m_age >= R_DLY && ((m_age - R_DLY) % R_PER) == 0) begin
                step = 1;
                idx  = (m_age - R_DLY) / R_PER + 1;
`ifdef PADDLE_ACCEL_EN
                if (idx > A_AFTER) size = 2 * P_STEP;
`else
                if (idx < 0) size = P_STEP;
`endif
            end
        end
        init_c = P_INIT;
        if (init_c < P_MIN) init_c = P_MIN;
        if (init_c > m_hi) init_c = m_hi;
        if (recenter)            m_pos = init_c;
        else if (m_pos > m_hi)   m_pos = m_hi;
        else if (m_pos < P_MIN)  m_pos = P_MIN;
        else if (step) begin
            if (m_dir) m_pos = (m_pos + size > m_hi) ? m_hi : m_pos + size;
            else       m_pos = (m_pos - size < P_MIN) ? P_MIN : m_pos - size;
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, "_pos"},    32'(pos),    32'(m_pos));
        chk({tag, "_at_min"}, 32'(at_min), 32'(m_pos == P_MIN));
        chk({tag, "_at_max"}, 32'(at_max), 32'(m_pos == m_hi));
        chk({tag, "_moving"}, 32'(moving), 32'(m_hold));
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        int saved;
        reset_n     = 1'b0;
        btn_dec     = 1'b0;
        btn_inc     = 1'b0;
        recenter    = 1'b0;
        paddlewidth = 6'd40;
        m_pos  = P_INIT;
        m_hold = 0;
        m_dir  = 0;
        m_age  = 0;
        #12;
        chk("reset_pos",    32'(pos),    32'(P_INIT));
        chk("reset_moving", 32'(moving), 32'd0);
        chk("reset_at_min", 32'(at_min), 32'd0);
        chk("reset_at_max", 32'(at_max), 32'd0);
        reset_n = 1'b1;
        ticks("idle", 2);

        // Hold-to-repeat timing: steps at cycles 0,4,6,8 of a 10-cycle hold.
        btn_inc = 1'b1;
        ticks("hold10", 10);
        btn_inc = 1'b0;
        tick("hold10_rel");
        chk("hold10_final_pos", 32'(pos), 32'd224);
        chk("hold10_final_moving", 32'(moving), 32'd0);
        $display("step hold10: pos=%0d", pos);

        // Asynchronous reset in the middle of a hold.
        btn_inc = 1'b1;
        ticks("prereset", 5);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_pos",    32'(pos),    32'(P_INIT));
        chk("async_reset_moving", 32'(moving), 32'd0);
        #3 reset_n = 1'b1;
        m_pos  = P_INIT;
        m_hold = 0;
        tick("post_reset");
        chk("post_reset_immediate_step", 32'(pos), 32'(P_INIT + 1));
        $display("step async_reset: pos=%0d", pos);

        // Saturate at the upper limit, then shrink the playfield.
        ticks("to_max", 500);
        chk("max_pos",    32'(pos),    32'd430);
        chk("max_at_max", 32'(at_max), 32'd1);
        paddlewidth = 6'd60;
        tick("width_grow");
        chk("width_grow_pos",    32'(pos),    32'd410);
        chk("width_grow_at_max", 32'(at_max), 32'd1);
        ticks("width_grow_hold", 3);
        btn_inc = 1'b0;
        tick("width_rel");
        $display("step upper_limit: pos=%0d at_max=%0d", pos, at_max);

        // Saturate at POS_MIN with no wrap.
        btn_dec = 1'b1;
        ticks("to_min", 900);
        chk("min_pos",    32'(pos),    32'(P_MIN));
        chk("min_at_min", 32'(at_min), 32'd1);
        btn_dec = 1'b0;
        tick("min_rel");
        $display("step lower_limit: pos=%0d at_min=%0d", pos, at_min);

        // Both buttons: no motion; dropping one gives an immediate step.
        saved   = int'(pos);
        btn_dec = 1'b1;
        btn_inc = 1'b1;
        ticks("both", 5);
        chk("both_pos",    32'(pos),    32'(saved));
        chk("both_moving", 32'(moving), 32'd0);
        btn_dec = 1'b0;
        tick("both_drop");
        chk("both_drop_pos", 32'(pos), 32'(saved + 1));
        btn_inc = 1'b0;
        tick("both_rel");
        $display("step both_buttons: pos=%0d", pos);

        // Recenter with a wide paddle, and recenter during a hold.
        paddlewidth = 6'd40;
        recenter = 1'b1;
        tick("recenter");
        recenter = 1'b0;
        chk("recenter_pos", 32'(pos), 32'(P_INIT));
`ifdef PADDLE_ACCEL_EN
        btn_inc = 1'b1;
        ticks("accel", 20);
        chk("accel_pos", 32'(pos), 32'd233);
        recenter = 1'b1;
        tick("accel_recenter");
        recenter = 1'b0;
        btn_inc = 1'b0;
        chk("accel_recenter_pos",    32'(pos),    32'(P_INIT));
        chk("accel_recenter_moving", 32'(moving), 32'd0);
        $display("step accel: pos=%0d", pos);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                btn_dec = 1'($urandom_range(0, 1));
                btn_inc = 1'($urandom_range(0, 1));
            end
            recenter = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 99) == 0) paddlewidth = 6'($urandom_range(0, 63));
            tick("rand");
        end
        $display("step random: pos=%0d", pos);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
